player_life_ctrl: RTL and testbench

- Sequences the player sprite's `visible` and `blink` controls and tracks remaining lives.
- Takes one-cycle hit and new-game pulses from game logic and a per-frame pulse from VGA timing.
- Runs lives, invulnerability blinking, the dying animation and game-over.
- Outputs feed the player bitmap's `visible`/`blink` inputs directly; `lives`/`gameOver` go to the score/HUD logic.

---
 rtl/player_life_ctrl.sv | 159 +++++++++++++++
 tb/tb_player_life_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/player_life_ctrl.sv
// Player sprite life sequencer: lives, post-hit blink, dying animation.
// Drives the player bitmap visible/blink and the HUD lives/gameOver.
module player_life_ctrl #(
  parameter int INIT_LIVES   = 3,
  parameter int INVUL_FRAMES = 120,
  parameter int DYING_FRAMES = 90,
  parameter int BLINK_PERIOD = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       startOfFrame,
  input  logic       newGame,
  input  logic       hit,
  output logic       visible,
  output logic       blink,
  output logic       invulnerable,
  output logic [2:0] lives,
  output logic       hitAck,
  output logic       gameOver
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ALIVE,
    S_INVUL,
    S_DYING,
    S_OVER
  } state_t;

  localparam logic [7:0] INVUL_LAST = 8'(INVUL_FRAMES - 1);
  localparam logic [7:0] DYING_LAST = 8'(DYING_FRAMES - 1);
  localparam logic [7:0] BLINK_LAST = 8'(BLINK_PERIOD - 1);
  localparam logic [2:0] LIVES_INIT = 3'(INIT_LIVES);

  state_t     r_state;
  state_t     w_state_nx;
  logic [7:0] r_fc;
  logic [7:0] r_bc;
  logic [7:0] w_fc_nx;
  logic [7:0] w_bc_nx;
  logic       r_visible;
  logic       r_blink;
  logic       r_invul;
  logic [2:0] r_lives;
  logic       r_ack;
  logic       r_go;
  logic       w_blink_nx;
  logic [2:0] w_lives_nx;
  logic       w_ack_nx;
  logic       w_blinking;
  logic       w_last;

  // INVUL and DYING share the frame/blink counters; only the end differs
  assign w_blinking = (r_state == S_INVUL) || (r_state == S_DYING);
  assign w_last     = (r_state == S_INVUL) ? (r_fc == INVUL_LAST)
                                           : (r_fc == DYING_LAST);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nx;
  end

  // Next-state: newGame overrides everything
  always_comb begin
    w_state_nx = r_state;
    if (newGame) begin
      w_state_nx = S_ALIVE;
    end else begin
      unique case (r_state)
        S_ALIVE:
          if (hit)
            w_state_nx = (r_lives > 3'd1) ? S_INVUL : S_DYING;
        S_INVUL:
          if (startOfFrame && w_last) w_state_nx = S_ALIVE;
        S_DYING:
          if (startOfFrame && w_last) w_state_nx = S_OVER;
        default: w_state_nx = r_state;
      endcase
    end
  end

  // Next values of counters, blink, lives and hit acknowledge
  always_comb begin
    w_fc_nx    = r_fc;
    w_bc_nx    = r_bc;
    w_blink_nx = r_blink;
    w_lives_nx = r_lives;
    w_ack_nx   = 1'b0;
    if (newGame) begin
      w_fc_nx    = '0;
      w_bc_nx    = '0;
      w_blink_nx = 1'b0;
      w_lives_nx = LIVES_INIT;
    end else if (r_state == S_ALIVE) begin
      w_blink_nx = 1'b0;
      if (hit) begin
        w_ack_nx   = 1'b1;
        w_fc_nx    = '0;
        w_bc_nx    = '0;
        w_blink_nx = 1'b1;
        w_lives_nx = (r_lives > 3'd1) ? r_lives - 3'd1 : 3'd0;
      end
    end else if (w_blinking) begin
      if (startOfFrame) begin
        if (w_last) begin
          w_fc_nx    = '0;
          w_bc_nx    = '0;
          w_blink_nx = 1'b0;
        end else begin
          w_fc_nx = r_fc + 8'd1;
          if (r_bc == BLINK_LAST) begin
            w_bc_nx    = '0;
            w_blink_nx = ~r_blink;
          end else begin
            w_bc_nx = r_bc + 8'd1;
          end
        end
      end
    end else if (r_state == S_OVER) begin
      w_blink_nx = 1'b0;
      w_lives_nx = 3'd0;
    end
  end

  // Registered outputs and counters, decoded from the next state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fc      <= '0;
      r_bc      <= '0;
      r_visible <= 1'b0;
      r_blink   <= 1'b0;
      r_invul   <= 1'b0;
      r_lives   <= '0;
      r_ack     <= 1'b0;
      r_go      <= 1'b0;
    end else begin
      r_fc      <= w_fc_nx;
      r_bc      <= w_bc_nx;
      r_blink   <= w_blink_nx;
      r_lives   <= w_lives_nx;
      r_ack     <= w_ack_nx;
      r_visible <= (w_state_nx == S_ALIVE) ||
                   (w_state_nx == S_INVUL) ||
                   (w_state_nx == S_DYING);
      r_invul   <= (w_state_nx == S_INVUL);
      r_go      <= (w_state_nx == S_DYING) ||
                   (w_state_nx == S_OVER);
    end
  end

  assign visible      = r_visible;
  assign blink        = r_blink;
  assign invulnerable = r_invul;
  assign lives        = r_lives;
  assign hitAck       = r_ack;
  assign gameOver     = r_go;

endmodule

// File: tb/tb_player_life_ctrl.sv
// Bench for player_life_ctrl: two parameter sets share one stimulus
// stream and are scored against a frames-since-hit life model.
module tb_player_life_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic startOfFrame = 1'b0;
  logic newGame = 1'b0;
  logic hit = 1'b0;

  logic       a_vis, a_blk, a_inv, a_ack, a_go;
  logic [2:0] a_liv;
  logic       b_vis, b_blk, b_inv, b_ack, b_go;
  logic [2:0] b_liv;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  player_life_ctrl dut_a (
    .clk(clk), .reset(reset), .startOfFrame(startOfFrame),
    .newGame(newGame), .hit(hit),
    .visible(a_vis), .blink(a_blk), .invulnerable(a_inv),
    .lives(a_liv), .hitAck(a_ack), .gameOver(a_go)
  );

  player_life_ctrl #(
    .INIT_LIVES(2), .INVUL_FRAMES(1),
    .DYING_FRAMES(3), .BLINK_PERIOD(1)
  ) dut_b (
    .clk(clk), .reset(reset), .startOfFrame(startOfFrame),
    .newGame(newGame), .hit(hit),
    .visible(b_vis), .blink(b_blk), .invulnerable(b_inv),
    .lives(b_liv), .hitAck(b_ack), .gameOver(b_go)
  );

  localparam int IDL = 0, ALV = 1, INV = 2, DY = 3, OVR = 4;
  int P_INIT[2] = '{3, 2};
  int P_INVF[2] = '{120, 1};
  int P_DYF[2]  = '{90, 3};
  int P_BP[2]   = '{8, 1};

  int m_mode[2];
  int m_lives[2];
  int m_n[2];
  bit m_ack[2];
  bit m_go[2];

  function automatic void mreset();
    for (int k = 0; k < 2; k++) begin
      m_mode[k] = IDL; m_lives[k] = 0; m_n[k] = 0;
      m_ack[k] = 0; m_go[k] = 0;
    end
  endfunction

  // One clock of game rules; m_n counts frames since the accepted hit
  function automatic void mstep(int k, bit ng, bit h, bit s);
    m_ack[k] = 0;
    if (ng) begin
      m_mode[k] = ALV; m_lives[k] = P_INIT[k];
      m_n[k] = 0; m_go[k] = 0;
    end else if (m_mode[k] == ALV && h) begin
      m_ack[k] = 1; m_n[k] = 0;
      if (m_lives[k] > 1) begin
        m_lives[k]--; m_mode[k] = INV;
      end else begin
        m_lives[k] = 0; m_mode[k] = DY; m_go[k] = 1;
      end
    end else if (m_mode[k] == INV && s) begin
      m_n[k]++;
      if (m_n[k] == P_INVF[k]) m_mode[k] = ALV;
    end else if (m_mode[k] == DY && s) begin
      m_n[k]++;
      if (m_n[k] == P_DYF[k]) m_mode[k] = OVR;
    end
  endfunction

  function automatic logic [7:0] expv(int k);
    logic v, b, i;
    v = (m_mode[k] == ALV) || (m_mode[k] == INV) || (m_mode[k] == DY);
    b = 1'b0;
    if (m_mode[k] == INV || m_mode[k] == DY)
      b = ((m_n[k] / P_BP[k]) % 2) == 0;
    i = (m_mode[k] == INV);
    return {v, b, i, 3'(m_lives[k]), m_ack[k], m_go[k]};
  endfunction

  function automatic logic [7:0] obsv(int k);
    if (k == 0) return {a_vis, a_blk, a_inv, a_liv, a_ack, a_go};
    return {b_vis, b_blk, b_inv, b_liv, b_ack, b_go};
  endfunction

  task automatic drive(input bit ng, input bit h, input bit s);
    @(negedge clk);
    newGame = ng; hit = h; startOfFrame = s;
    @(posedge clk);
    for (int k = 0; k < 2; k++) mstep(k, ng, h, s);
    #1;
    newGame = 0; hit = 0; startOfFrame = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    mreset();
    #1;
    for (int k = 0; k < 2; k++) begin
      n_tests++;
      if (obsv(k) !== 8'h00) begin
        n_fail++;
        $display("FAIL reset dut%0d got %b want %b", k, obsv(k), 8'h00);
      end
    end
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (obsv(0) !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_hold got %b want %b", obsv(0), 8'h00);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_new_game();
    drive(1, 0, 0);
    n_tests++;
    if (a_vis !== 1'b1 || a_liv !== 3'd3 || a_blk !== 1'b0 ||
        a_go !== 1'b0) begin
      n_fail++;
      $display("FAIL new_game got vis=%b liv=%0d blk=%b go=%b want 1 3 0 0",
               a_vis, a_liv, a_blk, a_go);
    end
    for (int k = 0; k < 2; k++) begin
      n_tests++;
      if (obsv(k) !== expv(k)) begin
        n_fail++;
        $display("FAIL new_game dut%0d got %b want %b", k, obsv(k), expv(k));
      end
    end
  endtask

  task automatic test_reset_mid_invul();
    drive(1, 0, 0);
    drive(0, 1, 0);
    drive(0, 0, 1);
    drive(0, 0, 0);
    #2 reset = 1'b1;
    mreset();
    #1;
    for (int k = 0; k < 2; k++) begin
      n_tests++;
      if (obsv(k) !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_mid dut%0d got %b want %b", k, obsv(k), 8'h00);
      end
    end
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      drive(0, 1, c[0]);
      for (int k = 0; k < 2; k++) begin
        n_tests++;
        if (obsv(k) !== expv(k)) begin
          n_fail++;
          $display("FAIL idle_hit dut%0d got %b want %b", k, obsv(k), expv(k));
        end
      end
    end
  endtask

  task automatic test_invul();
    drive(1, 0, 0);
    drive(0, 1, 0);
    n_tests++;
    if (a_ack !== 1'b1 || a_liv !== 3'd2 || a_inv !== 1'b1 ||
        a_blk !== 1'b1) begin
      n_fail++;
      $display("FAIL invul_entry got ack=%b liv=%0d inv=%b blk=%b want 1 2 1 1",
               a_ack, a_liv, a_inv, a_blk);
    end
    for (int f = 1; f <= 125; f++) begin
      drive(0, 0, 1);
      drive(0, f == 50, 0);
      for (int k = 0; k < 2; k++) begin
        n_tests++;
        if (obsv(k) !== expv(k)) begin
          n_fail++;
          $display("FAIL invul f=%0d dut%0d got %b want %b",
                   f, k, obsv(k), expv(k));
        end
      end
    end
  endtask

  task automatic test_game_over();
    drive(1, 0, 0);
    for (int h = 0; h < 3; h++) begin
      drive(0, 1, 0);
      for (int f = 0; f < 124; f++) begin
        drive(0, f == 60, 1);
        for (int k = 0; k < 2; k++) begin
          n_tests++;
          if (obsv(k) !== expv(k)) begin
            n_fail++;
            $display("FAIL game_over h=%0d f=%0d dut%0d got %b want %b",
                     h, f, k, obsv(k), expv(k));
          end
        end
      end
    end
    n_tests++;
    if (a_vis !== 1'b0 || a_go !== 1'b1 || a_liv !== 3'd0) begin
      n_fail++;
      $display("FAIL game_over_end got vis=%b go=%b liv=%0d want 0 1 0",
               a_vis, a_go, a_liv);
    end
  endtask

  task automatic test_hit_newgame();
    drive(1, 0, 0);
    drive(0, 1, 0);
    for (int f = 0; f < 121; f++) drive(0, 0, 1);
    drive(1, 1, 0);
    n_tests++;
    if (a_liv !== 3'd3 || a_ack !== 1'b0 || a_inv !== 1'b0 ||
        a_vis !== 1'b1) begin
      n_fail++;
      $display("FAIL hit_newgame got liv=%0d ack=%b inv=%b vis=%b want 3 0 0 1",
               a_liv, a_ack, a_inv, a_vis);
    end
    for (int k = 0; k < 2; k++) begin
      n_tests++;
      if (obsv(k) !== expv(k)) begin
        n_fail++;
        $display("FAIL hit_newgame dut%0d got %b want %b", k, obsv(k), expv(k));
      end
    end
  endtask

  task automatic test_hit_sof();
    drive(1, 0, 0);
    drive(0, 1, 1);
    for (int f = 1; f <= 121; f++) begin
      drive(0, 0, 1);
      for (int k = 0; k < 2; k++) begin
        n_tests++;
        if (obsv(k) !== expv(k)) begin
          n_fail++;
          $display("FAIL hit_sof f=%0d dut%0d got %b want %b",
                   f, k, obsv(k), expv(k));
        end
      end
    end
  endtask

  task automatic test_random();
    drive(1, 0, 0);
    for (int c = 0; c < 3000; c++) begin
      drive($urandom_range(0, 99) == 0,
            $urandom_range(0, 9) == 0,
            $urandom_range(0, 2) == 0);
      for (int k = 0; k < 2; k++) begin
        n_tests++;
        if (obsv(k) !== expv(k)) begin
          n_fail++;
          $display("FAIL random c=%0d dut%0d got %b want %b",
                   c, k, obsv(k), expv(k));
        end
      end
    end
  endtask

  initial begin
    mreset();
    test_reset();
    test_new_game();
    test_reset_mid_invul();
    test_new_game();
    test_invul();
    test_game_over();
    test_hit_newgame();
    test_hit_sof();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
